// File: rtl/led_pwm_dimmer_pkg.sv
// rtl/led_pwm_dimmer_pkg.sv - register map, field positions and widths for led_pwm_dimmer
package led_pwm_dimmer_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_BLINK    = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;
  localparam int CTRL_DUTY_LSB     = 8;

  localparam int DUTY_W  = 8;
  localparam int PRE_W   = 16;
  localparam int PWM_W   = 8;
  localparam int BLINK_W = 16;

  // Squared duty keeps full-on at full-on so DUTY 255 never drops a frame slot.
  function automatic logic [DUTY_W-1:0] gamma_duty(input logic [DUTY_W-1:0] duty);
    logic [2*DUTY_W-1:0] sq;
    sq = {{DUTY_W{1'b0}}, duty} * {{DUTY_W{1'b0}}, duty};
    return (duty == {DUTY_W{1'b1}}) ? {DUTY_W{1'b1}} : sq[2*DUTY_W-1:DUTY_W];
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// rtl/led_pwm_timebase.sv - prescaler, 8-bit PWM frame counter and blink phase generator
module led_pwm_timebase
  import led_pwm_dimmer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PRE_W-1:0]   i_prescale,
  input  logic [BLINK_W-1:0] i_blink_period,
  input  logic               i_prescale_load,
  input  logic               i_blink_load,
  output logic [PWM_W-1:0]   o_pwm_cnt,
  output logic               o_frame_end,
  output logic               o_phase
);

  logic [PRE_W-1:0]   r_pre_cnt;
  logic [PWM_W-1:0]   r_pwm_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;
  logic               w_tick;
  logic               w_frame_end;

  // A PRESCALE load restarts the prescaler and swallows any tick due that cycle.
  assign w_tick      = (r_pre_cnt == i_prescale) && !i_prescale_load;
  assign w_frame_end = w_tick && (r_pwm_cnt == {PWM_W{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt   <= '0;
      r_pwm_cnt   <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else begin
      if (i_prescale_load || w_tick)
        r_pre_cnt <= '0;
      else
        r_pre_cnt <= r_pre_cnt + 1'b1;

      if (w_tick)
        r_pwm_cnt <= r_pwm_cnt + 1'b1;

      if (i_blink_load) begin
        r_blink_cnt <= '0;
      end else if (w_frame_end) begin
        if (r_blink_cnt == i_blink_period) begin
          r_phase     <= ~r_phase;
          r_blink_cnt <= '0;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign o_pwm_cnt   = r_pwm_cnt;
  assign o_frame_end = w_frame_end;
  assign o_phase     = r_phase;

endmodule

// File: rtl/led_pwm_dimmer.sv
// rtl/led_pwm_dimmer.sv - PWM brightness and blink gate for the LEDG pins with a 4-register slave
// Optional gamma-corrected duty when LED_PWM_DIMMER_GAMMA_EN is defined.
module led_pwm_dimmer
  import led_pwm_dimmer_pkg::*;
#(
  parameter int N_LED        = 9,
  parameter int PRESCALE_RST = 49,
  parameter int BLINK_RST    = 976
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [N_LED-1:0] led_in,
  output logic [N_LED-1:0] led_out
);

  logic               r_en;
  logic               r_blink_en;
  logic [DUTY_W-1:0]  r_duty;
  logic [PRE_W-1:0]   r_prescale;
  logic [BLINK_W-1:0] r_blink_period;
  logic [N_LED-1:0]   r_led_out;

  logic               w_wr;
  logic               w_prescale_load;
  logic               w_blink_load;
  logic [PWM_W-1:0]   w_pwm_cnt;
  logic               w_frame_end;
  logic               w_phase;
  logic [DUTY_W-1:0]  w_eff_duty;
  logic [DUTY_W-1:0]  w_status_gamma;
  logic               w_pwm_on;
  logic               w_gate;
  logic               w_unused;

  assign w_wr            = chipselect && !write_n;
  assign w_prescale_load = w_wr && (address == ADDR_PRESCALE);
  assign w_blink_load    = w_wr && (address == ADDR_BLINK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en           <= 1'b0;
      r_blink_en     <= 1'b0;
      r_duty         <= '0;
      r_prescale     <= PRE_W'(PRESCALE_RST);
      r_blink_period <= BLINK_W'(BLINK_RST);
    end else if (w_wr) begin
      case (address)
        ADDR_CTRL: begin
          r_en       <= writedata[CTRL_EN_BIT];
          r_blink_en <= writedata[CTRL_BLINK_EN_BIT];
          r_duty     <= writedata[CTRL_DUTY_LSB +: DUTY_W];
        end
        ADDR_PRESCALE: r_prescale     <= writedata[PRE_W-1:0];
        ADDR_BLINK:    r_blink_period <= writedata[BLINK_W-1:0];
        default: ;
      endcase
    end
  end

  led_pwm_timebase u_timebase (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_prescale      (r_prescale),
    .i_blink_period  (r_blink_period),
    .i_prescale_load (w_prescale_load),
    .i_blink_load    (w_blink_load),
    .o_pwm_cnt       (w_pwm_cnt),
    .o_frame_end     (w_frame_end),
    .o_phase         (w_phase)
  );

`ifdef LED_PWM_DIMMER_GAMMA_EN
  assign w_eff_duty     = gamma_duty(r_duty);
  assign w_status_gamma = w_eff_duty;
`else
  assign w_eff_duty     = r_duty;
  assign w_status_gamma = '0;
`endif

  // Full-scale duty is forced on so the pwm_cnt == 255 slot does not blink off.
  assign w_pwm_on = (w_eff_duty == {DUTY_W{1'b1}}) || (w_pwm_cnt < w_eff_duty);
  assign w_gate   = w_pwm_on && (!r_blink_en || w_phase);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_led_out <= '0;
    else if (r_en)
      r_led_out <= led_in & {N_LED{w_gate}};
    else
      r_led_out <= led_in;
  end

  assign led_out = r_led_out;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN_BIT]                = r_en;
        readdata[CTRL_BLINK_EN_BIT]          = r_blink_en;
        readdata[CTRL_DUTY_LSB +: DUTY_W]    = r_duty;
      end
      ADDR_PRESCALE: readdata[PRE_W-1:0]   = r_prescale;
      ADDR_BLINK:    readdata[BLINK_W-1:0] = r_blink_period;
      default: begin
        readdata[0]     = w_phase;
        readdata[15:8]  = w_pwm_cnt;
        readdata[23:16] = w_status_gamma;
      end
    endcase
  end

  assign w_unused = &{1'b0, writedata[31:16], writedata[7:2], w_frame_end};

endmodule
